muib_param: RTL and testbench
=============================

Name: muib_param

Overview:
- Parametrised successor to the execute-stage M-extension unit; performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
- Adds a pipelined multiplier of configurable depth and a multi-bit-per-cycle iterative divider.
- Adds single-cycle divide special cases, a quotient/remainder reuse cache, a valid/ready handshake on both sides, and a flush input.
- Sits in the yurut stage beside the ALU and holds one operation in flight.

Parameters:
- XLEN, 32, operand/result width; must be even and >=8.
- CARP_ASAMA, 2, multiplier latency in clock edges from accept to sonuc_gecerli_o; range 1..4.
- BOL_BIT, 2, quotient bits resolved per divider cycle; must be 1 or 2 and divide XLEN.
- BOL_ONBELLEK, 1, 1 enables DIV/REM and DIVU/REMU result reuse.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- istek_gecerli_i  in  1  request valid.
- istek_hazir_o  out  1  unit can accept (state BOS).
- islem_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  XLEN  operand 1 (multiplicand/dividend).
- rs2_i  in  XLEN  operand 2 (multiplier/divisor).
- iptal_i  in  1  flush; kills the in-flight operation.
- sonuc_gecerli_o  out  1  result valid.
- sonuc_hazir_i  in  1  consumer accepts the result.
- sonuc_o  out  XLEN  result.
- mesgul_o  out  1  state != BOS.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to BOS; sonuc_gecerli_o=0, sonuc_o=0, mesgul_o=0, istek_hazir_o=1.
  - Cache is invalidated and the divider core is cleared.
  - Reset mid-operation aborts it and no result is produced.
- Accept: an edge with istek_gecerli_i && istek_hazir_o && !iptal_i. Operands and islem_i are registered. No second accept until the result has been taken.
- States: BOS, CARP, BOL, DUZELT, SONUC.
- BOS:
  - MUL group: go to CARP.
  - Divide group with a cache hit, rs2==0, or signed overflow (rs1==100..0, rs2==all ones, DIV/REM): go to SONUC directly (1-edge latency).
  - Any other divide: go to BOL.
- CARP: a counter runs CARP_ASAMA-1 edges, then the state moves to SONUC. sonuc_gecerli_o rises exactly CARP_ASAMA edges after accept.
- Multiply product width:
  - The 2*XLEN product is taken from operands sign-extended to XLEN+1 bits per operation: MULH s×s, MULHSU s×u, MULHU u×u, MUL either.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- BOL:
  - Non-restoring iteration on absolute values, BOL_BIT quotient bits per edge, XLEN/BOL_BIT edges.
  - Then DUZELT for 1 edge: sign correction, quotient negated if signs differ, remainder takes the dividend sign.
  - Normal divide latency = XLEN/BOL_BIT+1 edges.
- Special cases:
  - rs2==0: quotient = all ones, remainder = rs1.
  - Signed overflow: quotient = rs1, remainder = 0.
- Cache (BOL_ONBELLEK=1):
  - After any divide completes, store {rs1, rs2, signedness, quotient, remainder}.
  - A hit requires the same operands and signedness; the other half of the pair is then returned in 1 edge.
  - Invalidated by iptal_i or reset.
- SONUC:
  - sonuc_gecerli_o=1 and sonuc_o is held stable while sonuc_hazir_i=0.
  - An edge with sonuc_hazir_i=1 moves to BOS, and the next request can be accepted on the following edge.
- iptal_i:
  - Has priority in every state; the next edge goes to BOS with sonuc_gecerli_o=0.
  - iptal_i coinciding with istek_gecerli_i in BOS: the request is not accepted.
  - iptal_i in SONUC coinciding with sonuc_hazir_i: treated as consumed.
- sonuc_o is 0 outside SONUC.

Decomposition:
- Shared package muib_param_pkg holds:
  - muib_islem_e, the 3-bit funct3 enum;
  - muib_durum_e, the state enum;
  - the islem_bolme_mi, islem_isaretli_mi, islem_yuksek_mi helper functions.
- Sub-module muib_bolucu_cekirdek: parametrised (XLEN, BOL_BIT) iterative unsigned divider core with basla_i, adim counter, bitti_o, bolum_o and kalan_o.
- The multiplier pipeline and the FSM stay in the top module.

Test Plan (XLEN=32, CARP_ASAMA=2, BOL_BIT=2):
- MUL 7 × 0xFFFFFFFD: sonuc_gecerli_o is high 2 edges after accept, with 0xFFFFFFEB.
- MULHU / MULH / MULHSU on 0xFFFFFFFF, 0xFFFFFFFF: results 0xFFFFFFFE, 0x00000000 and 0xFFFFFFFF respectively.
- DIV 0xFFFFFFF9 / 2: result 0xFFFFFFFD, valid at edge 17. REM on the same operands: 0xFFFFFFFF via cache hit in 1 edge.
- Divide special cases:
  - DIVU 5/0: 0xFFFFFFFF.
  - REMU 5/0: 5.
  - DIV 0x80000000/0xFFFFFFFF: 0x80000000.
  - REM 0x80000000/0xFFFFFFFF: 0.
  - Each valid after 1 edge with no BOL cycles.
- Hold sonuc_hazir_i=0 for 5 cycles: sonuc_o and sonuc_gecerli_o stay stable; istek_hazir_o=0 throughout, then 1 one edge after the handshake.
- Flush and reset:
  - iptal_i at BOL edge 6: no sonuc_gecerli_o, and the next DIV 100/7 misses the cache and returns 14.
  - rst_i pulsed mid-CARP: all outputs immediately go to their reset values.

Source files
------------

// File: rtl/muib_param_pkg.sv
// Shared types and decode helpers for the parametrised M-extension unit.
package muib_param_pkg;

  typedef enum logic [2:0] {
    ISLEM_MUL    = 3'b000,
    ISLEM_MULH   = 3'b001,
    ISLEM_MULHSU = 3'b010,
    ISLEM_MULHU  = 3'b011,
    ISLEM_DIV    = 3'b100,
    ISLEM_DIVU   = 3'b101,
    ISLEM_REM    = 3'b110,
    ISLEM_REMU   = 3'b111
  } muib_islem_e;

  typedef enum logic [2:0] {
    BOS,
    CARP,
    BOL,
    DUZELT,
    SONUC
  } muib_durum_e;

  function automatic logic islem_bolme_mi(input logic [2:0] islem);
    return islem[2];
  endfunction

  // True when rs1 is interpreted as a signed value.
  function automatic logic islem_isaretli_mi(input logic [2:0] islem);
    return (islem == ISLEM_MULH) || (islem == ISLEM_MULHSU) ||
           (islem == ISLEM_DIV)  || (islem == ISLEM_REM);
  endfunction

  // High product half for multiplies, remainder for divides.
  function automatic logic islem_yuksek_mi(input logic [2:0] islem);
    return islem[2] ? islem[1] : (islem[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/muib_bolucu_cekirdek.sv
// Iterative unsigned non-restoring divider resolving BOL_BIT quotient bits per edge.
// The basla_i edge already performs the first iteration on the fresh operands.
module muib_bolucu_cekirdek import muib_param_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int BOL_BIT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            temizle_i,
  input  logic            basla_i,
  input  logic [XLEN-1:0] bolunen_i,
  input  logic [XLEN-1:0] bolen_i,
  output logic            bitti_o,
  output logic [XLEN-1:0] bolum_o,
  output logic [XLEN-1:0] kalan_o
);

  localparam int ADIM_SAYI = XLEN / BOL_BIT;
  localparam int AW        = $clog2(ADIM_SAYI + 1);

  logic [XLEN:0]   kalan;
  logic [XLEN-1:0] bolum;
  logic [XLEN-1:0] bolen;
  logic [AW-1:0]   adim;
  logic            calisiyor;

  logic [XLEN:0]   kalan_t;
  logic [XLEN-1:0] bolum_t;
  logic [XLEN-1:0] bolen_t;

  // Partial remainder stays within (-d, d), so XLEN+1 bits of modular arithmetic suffice.
  always_comb begin
    kalan_t = basla_i ? '0 : kalan;
    bolum_t = basla_i ? bolunen_i : bolum;
    bolen_t = basla_i ? bolen_i : bolen;
    for (int i = 0; i < BOL_BIT; i++) begin
      if (!kalan_t[XLEN])
        kalan_t = {kalan_t[XLEN-1:0], bolum_t[XLEN-1]} - {1'b0, bolen_t};
      else
        kalan_t = {kalan_t[XLEN-1:0], bolum_t[XLEN-1]} + {1'b0, bolen_t};
      bolum_t = {bolum_t[XLEN-2:0], ~kalan_t[XLEN]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kalan     <= '0;
      bolum     <= '0;
      bolen     <= '0;
      adim      <= '0;
      calisiyor <= 1'b0;
    end else if (temizle_i) begin
      adim      <= '0;
      calisiyor <= 1'b0;
    end else if (basla_i || calisiyor) begin
      kalan     <= kalan_t;
      bolum     <= bolum_t;
      bolen     <= bolen_t;
      adim      <= basla_i ? AW'(1) : adim + 1'b1;
      calisiyor <= basla_i || !bitti_o;
    end
  end

  assign bitti_o = calisiyor && (adim == AW'(ADIM_SAYI - 1));
  assign bolum_o = bolum;
  // A negative final partial remainder still owes one restoring add.
  assign kalan_o = kalan[XLEN] ? (kalan[XLEN-1:0] + bolen) : kalan[XLEN-1:0];

endmodule

// File: rtl/muib_param.sv
// Execute-stage M-extension unit: delayed multiplier, iterative divider,
// single-edge divide special cases and a quotient/remainder reuse cache.
module muib_param import muib_param_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int CARP_ASAMA   = 2,
  parameter int BOL_BIT      = 2,
  parameter int BOL_ONBELLEK = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            istek_gecerli_i,
  output logic            istek_hazir_o,
  input  logic [2:0]      islem_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            iptal_i,
  output logic            sonuc_gecerli_o,
  input  logic            sonuc_hazir_i,
  output logic [XLEN-1:0] sonuc_o,
  output logic            mesgul_o
);

  localparam logic [1:0]      SAYAC_BAS = (CARP_ASAMA > 1) ? 2'(CARP_ASAMA - 2) : 2'd0;
  localparam logic [XLEN-1:0] EN_KUCUK  = {1'b1, {(XLEN-1){1'b0}}};

  muib_durum_e durum, sonraki;
  logic            kabul, basla;
  logic            kalan_sec, isaretli_r, bolunen_neg, bolen_neg;
  logic [XLEN-1:0] rs1_r, rs2_r, sonuc_r;
  logic [1:0]      sayac;

  logic            onb_gecerli, onb_isaretli;
  logic [XLEN-1:0] onb_rs1, onb_rs2, onb_bolum, onb_kalan;

  logic            bolme, isaretli, rs2_isaretli, sifir_bolen, tasma, isabet, dogrudan;
  logic [XLEN-1:0] dogrudan_sonuc, carp_sonuc, bolunen_mutlak, bolen_mutlak;
  logic [XLEN:0]   carp_a, carp_b;
  logic [2*XLEN-1:0] carpim;
  logic            bitti;
  logic [XLEN-1:0] bolum_ham, kalan_ham, bolum_duz, kalan_duz;

  assign bolme        = islem_bolme_mi(islem_i);
  assign isaretli     = islem_isaretli_mi(islem_i);
  assign rs2_isaretli = (islem_i == ISLEM_MULH) || (bolme && isaretli);
  assign sifir_bolen  = (rs2_i == '0);
  assign tasma        = isaretli && (rs1_i == EN_KUCUK) && (rs2_i == '1);
  assign isabet       = (BOL_ONBELLEK != 0) && onb_gecerli && (onb_rs1 == rs1_i) &&
                        (onb_rs2 == rs2_i) && (onb_isaretli == isaretli);
  assign dogrudan     = isabet || sifir_bolen || tasma;

  always_comb begin
    dogrudan_sonuc = '0;
    if (isabet)
      dogrudan_sonuc = islem_yuksek_mi(islem_i) ? onb_kalan : onb_bolum;
    else if (sifir_bolen)
      dogrudan_sonuc = islem_yuksek_mi(islem_i) ? rs1_i : '1;
    else if (tasma)
      dogrudan_sonuc = islem_yuksek_mi(islem_i) ? '0 : rs1_i;
  end

  // Operands widened to XLEN+1 bits so one signed multiply covers every variant.
  assign carp_a     = {isaretli && rs1_i[XLEN-1], rs1_i};
  assign carp_b     = {rs2_isaretli && rs2_i[XLEN-1], rs2_i};
  assign carpim     = {{(XLEN-1){carp_a[XLEN]}}, carp_a} * {{(XLEN-1){carp_b[XLEN]}}, carp_b};
  assign carp_sonuc = islem_yuksek_mi(islem_i) ? carpim[2*XLEN-1:XLEN] : carpim[XLEN-1:0];

  assign bolunen_mutlak = (isaretli && rs1_i[XLEN-1]) ? ('0 - rs1_i) : rs1_i;
  assign bolen_mutlak   = (isaretli && rs2_i[XLEN-1]) ? ('0 - rs2_i) : rs2_i;

  muib_bolucu_cekirdek #(
    .XLEN    (XLEN),
    .BOL_BIT (BOL_BIT)
  ) u_bolucu (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (iptal_i),
    .basla_i   (basla),
    .bolunen_i (bolunen_mutlak),
    .bolen_i   (bolen_mutlak),
    .bitti_o   (bitti),
    .bolum_o   (bolum_ham),
    .kalan_o   (kalan_ham)
  );

  assign bolum_duz = (bolunen_neg ^ bolen_neg) ? ('0 - bolum_ham) : bolum_ham;
  assign kalan_duz = bolunen_neg ? ('0 - kalan_ham) : kalan_ham;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum <= BOS;
    else       durum <= sonraki;
  end

  always_comb begin
    sonraki = durum;
    kabul   = 1'b0;
    basla   = 1'b0;
    if (iptal_i) begin
      sonraki = BOS;
    end else begin
      case (durum)
        BOS: if (istek_gecerli_i) begin
          kabul = 1'b1;
          if (!bolme) begin
            if (CARP_ASAMA > 1) sonraki = CARP;
            else                sonraki = SONUC;
          end else if (dogrudan) begin
            sonraki = SONUC;
          end else begin
            sonraki = BOL;
            basla   = 1'b1;
          end
        end
        CARP:    if (sayac == 2'd0) sonraki = SONUC;
        BOL:     if (bitti) sonraki = DUZELT;
        DUZELT:  sonraki = SONUC;
        SONUC:   if (sonuc_hazir_i) sonraki = BOS;
        default: sonraki = BOS;
      endcase
    end
  end

  // Special-case divides also fill the cache, since both halves are known up front.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kalan_sec    <= 1'b0;
      isaretli_r   <= 1'b0;
      bolunen_neg  <= 1'b0;
      bolen_neg    <= 1'b0;
      rs1_r        <= '0;
      rs2_r        <= '0;
      sonuc_r      <= '0;
      sayac        <= '0;
      onb_gecerli  <= 1'b0;
      onb_isaretli <= 1'b0;
      onb_rs1      <= '0;
      onb_rs2      <= '0;
      onb_bolum    <= '0;
      onb_kalan    <= '0;
    end else if (iptal_i) begin
      onb_gecerli <= 1'b0;
    end else if (kabul) begin
      kalan_sec   <= islem_yuksek_mi(islem_i);
      isaretli_r  <= isaretli;
      bolunen_neg <= isaretli && rs1_i[XLEN-1];
      bolen_neg   <= isaretli && rs2_i[XLEN-1];
      rs1_r       <= rs1_i;
      rs2_r       <= rs2_i;
      sayac       <= SAYAC_BAS;
      sonuc_r     <= bolme ? dogrudan_sonuc : carp_sonuc;
      if (bolme && dogrudan && !isabet) begin
        onb_gecerli  <= (BOL_ONBELLEK != 0);
        onb_isaretli <= isaretli;
        onb_rs1      <= rs1_i;
        onb_rs2      <= rs2_i;
        onb_bolum    <= sifir_bolen ? '1 : rs1_i;
        onb_kalan    <= sifir_bolen ? rs1_i : '0;
      end
    end else if (durum == CARP && sayac != 2'd0) begin
      sayac <= sayac - 1'b1;
    end else if (durum == DUZELT) begin
      sonuc_r      <= kalan_sec ? kalan_duz : bolum_duz;
      onb_gecerli  <= (BOL_ONBELLEK != 0);
      onb_isaretli <= isaretli_r;
      onb_rs1      <= rs1_r;
      onb_rs2      <= rs2_r;
      onb_bolum    <= bolum_duz;
      onb_kalan    <= kalan_duz;
    end
  end

  assign istek_hazir_o   = (durum == BOS);
  assign mesgul_o        = (durum != BOS);
  assign sonuc_gecerli_o = (durum == SONUC);
  assign sonuc_o         = (durum == SONUC) ? sonuc_r : '0;

endmodule

// File: tb/tb_muib_param.sv
// Self-checking bench for muib_param: directed table, corner-case sequences
// and randomized operations checked against an arithmetic reference model.
module tb_muib_param;

  localparam int XLEN       = 32;
  localparam int CARP_ASAMA = 2;
  localparam int BOL_BIT    = 2;
  localparam int DIV_LAT    = XLEN / BOL_BIT + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            istek_gecerli;
  logic            istek_hazir;
  logic [2:0]      islem;
  logic [XLEN-1:0] rs1, rs2;
  logic            iptal;
  logic            sonuc_gecerli;
  logic            sonuc_hazir;
  logic [XLEN-1:0] sonuc;
  logic            mesgul;

  always #5 clk = ~clk;

  muib_param #(
    .XLEN         (XLEN),
    .CARP_ASAMA   (CARP_ASAMA),
    .BOL_BIT      (BOL_BIT),
    .BOL_ONBELLEK (1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .istek_gecerli_i (istek_gecerli),
    .istek_hazir_o   (istek_hazir),
    .islem_i         (islem),
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .iptal_i         (iptal),
    .sonuc_gecerli_o (sonuc_gecerli),
    .sonuc_hazir_i   (sonuc_hazir),
    .sonuc_o         (sonuc),
    .mesgul_o        (mesgul)
  );

  int vec_count   = 0;
  int miscompares = 0;

  // Reference view of the reuse cache: last completed divide and its signedness.
  logic            model_cache_valid = 1'b0;
  logic [XLEN-1:0] model_a = '0, model_b = '0;
  logic            model_sgn = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = signed'(a);
    sb = signed'(b);
    p  = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = !op[0];
    if (!op[2]) return CARP_ASAMA;
    if (b == 0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    if (model_cache_valid && model_a == a && model_b == b && model_sgn == sgn) return 1;
    return DIV_LAT;
  endfunction

  // Issues one request from an idle DUT, measures edges to valid, checks, then consumes.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat, input string name);
    int edges;
    checkOutput({name, " ready"}, 32'(istek_hazir), 32'd1);
    istek_gecerli = 1'b1;
    islem         = op;
    rs1           = a;
    rs2           = b;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    edges = 1;
    while (!sonuc_gecerli && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, " latency"}, 32'(edges), 32'(exp_lat));
    checkOutput({name, " result"}, sonuc, exp_res);
    if (op[2]) begin
      model_cache_valid = 1'b1;
      model_a           = a;
      model_b           = b;
      model_sgn         = !op[0];
    end
    if (sonuc_gecerli) begin
      sonuc_hazir = 1'b1;
      @(posedge clk); #1;
      sonuc_hazir = 1'b0;
    end else begin
      iptal = 1'b1;
      @(posedge clk); #1;
      iptal = 1'b0;
      model_cache_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int seen_valid;

    tbl[0] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, CARP_ASAMA, "MUL 7*-3"};
    tbl[1] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, CARP_ASAMA, "MULHU"};
    tbl[2] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, CARP_ASAMA, "MULH"};
    tbl[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, CARP_ASAMA, "MULHSU"};
    tbl[4] = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT,    "DIV -7/2"};
    tbl[5] = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1,          "REM -7/2 hit"};
    tbl[6] = '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1,          "DIVU 5/0"};
    tbl[7] = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1,          "REMU 5/0"};
    tbl[8] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,          "DIV ovf"};
    tbl[9] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,          "REM ovf"};

    rst = 1'b1; istek_gecerli = 1'b0; islem = '0; rs1 = '0; rs2 = '0;
    iptal = 1'b0; sonuc_hazir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid", 32'(sonuc_gecerli), 32'd0);
    checkOutput("reset result", sonuc, 32'd0);
    checkOutput("reset busy", 32'(mesgul), 32'd0);
    checkOutput("reset ready", 32'(istek_hazir), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_res, tbl[i].exp_lat, tbl[i].name);

    // Result held while the consumer stalls.
    istek_gecerli = 1'b1; islem = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold valid", 32'(sonuc_gecerli), 32'd1);
      checkOutput("hold result", sonuc, 32'd15);
      checkOutput("hold ready", 32'(istek_hazir), 32'd0);
      @(posedge clk); #1;
    end
    sonuc_hazir = 1'b1;
    @(posedge clk); #1;
    sonuc_hazir = 1'b0;
    checkOutput("ready after handshake", 32'(istek_hazir), 32'd1);
    checkOutput("valid after handshake", 32'(sonuc_gecerli), 32'd0);
    applyStimulus(3'd0, 32'd6, 32'd7, 32'd42, CARP_ASAMA, "MUL back-to-back");

    // Flush mid-divide must invalidate the cache.
    applyStimulus(3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIV 100/7 first");
    applyStimulus(3'd6, 32'd100, 32'd7, 32'd2, 1, "REM 100/7 hit");
    istek_gecerli = 1'b1; islem = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    iptal = 1'b1;
    @(posedge clk); #1;
    iptal = 1'b0;
    model_cache_valid = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (sonuc_gecerli) seen_valid++;
      @(posedge clk); #1;
    end
    checkOutput("flush no result", 32'(seen_valid), 32'd0);
    checkOutput("flush busy", 32'(mesgul), 32'd0);
    applyStimulus(3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIV 100/7 after flush");

    // Flush together with a request: nothing accepted.
    istek_gecerli = 1'b1; iptal = 1'b1; islem = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    istek_gecerli = 1'b0; iptal = 1'b0;
    model_cache_valid = 1'b0;
    checkOutput("flush+request busy", 32'(mesgul), 32'd0);
    checkOutput("flush+request ready", 32'(istek_hazir), 32'd1);

    // Asynchronous reset while the multiplier is counting.
    applyStimulus(3'd4, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIV 100/7 refill");
    istek_gecerli = 1'b1; islem = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    checkOutput("CARP busy", 32'(mesgul), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async reset valid", 32'(sonuc_gecerli), 32'd0);
    checkOutput("async reset result", sonuc, 32'd0);
    checkOutput("async reset busy", 32'(mesgul), 32'd0);
    checkOutput("async reset ready", 32'(istek_hazir), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cache_valid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(3'd6, 32'd100, 32'd7, 32'd2, DIV_LAT, "REM 100/7 after reset");

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          mode;
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2, 3: if (model_cache_valid) begin
          a  = model_a;
          b  = model_b;
          op = {1'b1, 1'($urandom_range(0, 1)), ~model_sgn};
        end
        4: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      applyStimulus(op, a, b, ref_result(op, a, b), ref_latency(op, a, b),
                    $sformatf("rand%0d op%0d", n, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
